// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider (seq_divider).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Fill bit for the divide-by-zero quotient: replicated to WIDTH gives all ones.
  localparam logic DIV0_QUOT_BIT = 1'b1;

  // Step counter must hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: trial-subtract the divisor from the
// partial remainder shifted left by one dividend bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_diff_bit;

  assign shifted = {a, q[WIDTH-1]};
  // One extra bit beyond the (WIDTH+1)-bit difference carries the borrow.
  assign diff = {1'b0, shifted} - {2'b00, dvsr};
  assign unused_diff_bit = diff[WIDTH];

  // A < divisor always holds, so a successful difference fits in WIDTH bits
  // and a failed one never loses a set bit from the shifted remainder.
  always_comb begin
    a_next = shifted[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      a_next = diff[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider with start/ready handshake.
// Define SEQ_DIVIDER_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception
);

  localparam int CW = cnt_width(WIDTH);

  // Handshake: start is accepted on any edge where the FSM is IDLE or DONE
  // (busy low); ready pulses for the single DONE cycle, and quotient,
  // remainder and exception change only on the edge that raises ready.
  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, q_q, dvsr_q, dvnd_raw_q;
  logic             neg_quo_q, neg_rem_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_step, q_step;
  logic [WIDTH-1:0] dvnd_mag, dvsr_mag, quo_fix, rem_fix;
  logic             dvnd_neg, dvsr_neg, accept, divisor_zero;

  assign accept       = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign dvnd_neg = is_signed & dividend[WIDTH-1];
  assign dvsr_neg = is_signed & divisor[WIDTH-1];
  assign dvnd_mag = dvnd_neg ? -dividend : dividend;
  assign dvsr_mag = dvsr_neg ? -divisor : divisor;
  // MIN / -1 yields magnitude 2^(WIDTH-1); negating it wraps back to MIN.
  assign quo_fix  = neg_quo_q ? -q_q : q_q;
  assign rem_fix  = neg_rem_q ? -a_q : a_q;
`else
  logic unused_sign;
  assign dvnd_neg    = 1'b0;
  assign dvsr_neg    = 1'b0;
  assign dvnd_mag    = dividend;
  assign dvsr_mag    = divisor;
  assign quo_fix     = q_q;
  assign rem_fix     = a_q;
  assign unused_sign = is_signed ^ neg_quo_q ^ neg_rem_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .q      (q_q),
    .dvsr   (dvsr_q),
    .a_next (a_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (!start)            state_d = IDLE;
        else if (divisor_zero) state_d = FIX;
        else                   state_d = RUN;
      end
      RUN:     if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN) || (state_q == FIX);
    ready = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      q_q        <= '0;
      dvsr_q     <= '0;
      dvnd_raw_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      cnt_q      <= '0;
      quotient   <= '0;
      remainder  <= '0;
      exception  <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= '0;
        q_q        <= dvnd_mag;
        dvsr_q     <= dvsr_mag;
        dvnd_raw_q <= dividend;
        neg_quo_q  <= dvnd_neg ^ dvsr_neg;
        neg_rem_q  <= dvnd_neg;
        zero_q     <= divisor_zero;
        cnt_q      <= CW'(WIDTH);
      end else if (state_q == RUN) begin
        a_q   <= a_step;
        q_q   <= q_step;
        cnt_q <= cnt_q - CW'(1);
      end else if (state_q == FIX) begin
        if (zero_q) begin
          quotient  <= {WIDTH{DIV0_QUOT_BIT}};
          remainder <= dvnd_raw_q;
          exception <= 1'b1;
        end else begin
          quotient  <= quo_fix;
          remainder <= rem_fix;
          exception <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, random ops against a
// reference model, plus ignored-start, back-to-back and reset-abort sequences.
module tb_seq_divider;

  localparam int WIDTH = 32;
  localparam int RW    = 2 * WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst, start, is_signed;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, ready, exception;
  logic [WIDTH-1:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_out;

  typedef struct {
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
    logic             s;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             e;
  } vec_t;

  vec_t vecs[13];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder),
    .exception (exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                                          input logic s);
    logic [WIDTH-1:0] q, r;
    longint sn, sd;
    if (d == '0) return {1'b1, {WIDTH{1'b1}}, n};
    q = n / d;
    r = n % d;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (s) begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      q  = WIDTH'(sn / sd);
      r  = WIDTH'(sn % sd);
    end
`else
    sn = 0;
    sd = longint'(s);
`endif
    return {1'b0, q, r};
  endfunction

  task automatic set_vec(input int i, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                         input logic s, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                         input logic e);
    vecs[i].n = n; vecs[i].d = d; vecs[i].s = s;
    vecs[i].q = q; vecs[i].r = r; vecs[i].e = e;
  endtask

  // Result scoreboard and output-hold monitor.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=%h required=none", {exception, quotient, remainder});
        end else begin
          check("result", {exception, quotient, remainder}, exp_q.pop_front());
        end
      end else begin
        check("hold", {exception, quotient, remainder}, last_out);
      end
    end
    last_out = {exception, quotient, remainder};
  end

  // Runs one operation; poke >= 0 pulses start with junk operands that many cycles in.
  task automatic do_op(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d, input logic s,
                       input logic [RW-1:0] exp, input int poke);
    int  n_cyc, busy_cyc, lat;
    bit  done;
    @(negedge clk);
    start = 1'b1; dividend = n; divisor = d; is_signed = s;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    busy_cyc = busy ? 1 : 0;
    n_cyc = 0;
    done = 0;
    while (!done && n_cyc < 100) begin
      if (n_cyc == poke) begin
        @(negedge clk);
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9);
      end
      @(posedge clk); #1;
      if (n_cyc == poke) start = 1'b0;
      n_cyc++;
      if (ready) done = 1;
      else if (busy) busy_cyc++;
    end
    lat = (d == '0) ? 1 : WIDTH + 1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=no_ready required=ready_within_100");
    end else begin
      check("latency", RW'(n_cyc), RW'(lat));
      check("busy_cycles", RW'(busy_cyc), RW'(lat));
      check("busy_at_ready", RW'(busy), RW'(0));
      @(posedge clk); #1;
      check("ready_pulse", RW'(ready), RW'(0));
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] rn, rd;
    logic             rs;
    int               t;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    set_vec(0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    set_vec(3, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
    set_vec(4, 32'd6, 32'd3, 1'b0, 32'd2, 32'd0, 1'b0);
    set_vec(6, 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
    set_vec(7, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
    set_vec(8, 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
    set_vec(9, 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    set_vec(10, 32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b0);
    set_vec(11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    set_vec(1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    set_vec(2, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
    set_vec(5, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    set_vec(12, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0);
`else
    set_vec(1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0);
    set_vec(2, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 1'b0);
    set_vec(5, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0);
    set_vec(12, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd0, 32'hFFFFFF9C, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_result", {exception, quotient, remainder}, '0);
    check("reset_flags", RW'({busy, ready}), RW'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].n, vecs[i].d, vecs[i].s, {vecs[i].e, vecs[i].q, vecs[i].r}, -1);

    // start pulsed on cycle 10 of a running op must be ignored.
    do_op(32'd100, 32'd7, 1'b0, {1'b0, 32'd14, 32'd2}, 9);

    for (int i = 0; i < 12; i++) begin
      rn = $urandom;
      case ($urandom_range(0, 3))
        0:       rd = '0;
        1:       rd = WIDTH'($urandom_range(1, 15));
        2:       rd = {{(WIDTH-4){1'b1}}, 4'($urandom_range(0, 15))};
        default: rd = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_op(rn, rd, rs, model(rn, rd, rs), -1);
    end

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    exp_q.push_back({1'b0, 32'd14, 32'd2});
    @(posedge clk); #1;
    dividend = 32'd45; divisor = 32'd6;
    exp_q.push_back({1'b0, 32'd7, 32'd3});
    t = 0;
    while (!ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_first_latency", RW'(t), RW'(WIDTH + 1));
    @(posedge clk); #1;
    start = 1'b0;
    t = 1;
    while (!ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_period", RW'(t), RW'(WIDTH + 2));
    @(posedge clk); #1;

    // Reset aborts an op in flight; its result must never appear.
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_result", {exception, quotient, remainder}, '0);
    check("abort_flags", RW'({busy, ready}), RW'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    do_op(32'd1000, 32'd3, 1'b0, {1'b0, 32'd333, 32'd1}, -1);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", RW'(exp_q.size()), RW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
